// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;
  localparam logic [3:0] DIGIT_NINE = 4'h9;

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Start/done handshake and result bus between a requester and bcd_seq_converter.
interface bcd_seq_converter_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= ADJ_THRESH) ? digit_in + ADJ_ADD : digit_in;

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter, one input bit per clock, held result.
// Build option: define BCD_SATURATE_EN to force all-nines bcd on overflow.
//
// state | meaning
// IDLE  | waiting for start; bcd/overflow hold the last result
// SHIFT | one adjust+shift per cycle, BIN_W cycles
// DONE  | result published, done pulse
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  bcd_seq_converter_if.slave  bus
);

  localparam int             BCD_W    = DIGIT_W * DIGITS;
  localparam int             CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   scratch, scratch_adj, scratch_nxt, result;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_sticky, ovf_nxt, ovf_q;
  logic               last_bit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[g*DIGIT_W +: DIGIT_W]),
      .digit_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Scratch and binary register shift as one vector; the scratch MSB falls into the sticky flag.
  assign scratch_nxt = {scratch_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign ovf_nxt     = ovf_sticky | scratch_adj[BCD_W-1];
  assign last_bit    = (cnt == CNT_ONE);

`ifdef BCD_SATURATE_EN
  assign result = ovf_nxt ? {DIGITS{DIGIT_NINE}} : scratch_nxt;
`else
  assign result = scratch_nxt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state == SHIFT);
    bus.done     = (state == DONE);
    bus.bcd      = bcd_q;
    bus.overflow = ovf_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      bin_sr     <= '0;
      scratch    <= '0;
      ovf_sticky <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr     <= bus.bin;
            scratch    <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CNT_LOAD;
          end
        end
        SHIFT: begin
          scratch    <= scratch_nxt;
          bin_sr     <= {bin_sr[BIN_W-2:0], 1'b0};
          ovf_sticky <= ovf_nxt;
          cnt        <= cnt - CNT_ONE;
          // Result registers only move on the final shift, so bcd never shows a partial value.
          if (last_bit) begin
            bcd_q <= result;
            ovf_q <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
